sic_mem_access_unit: RTL and testbench



---
 rtl/sic_mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_sic_mem_access_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sic_mem_access_unit.sv
// CPU-side access unit for the SIC 24-bit-word, byte-addressable memory.
// Sequences word/byte loads and stores over a valid/ready handshake; byte stores run as read-modify-write.
module sic_mem_access_unit #(
  parameter int MEMORY_SIZE   = 32768,
  parameter int DATA_SIZE     = 24,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic                     req_byte_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_SIZE-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_SIZE-1:0]     rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     mem_write_enable_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_o,
  output logic [DATA_SIZE-1:0]     mem_write_data_o,
  input  logic [DATA_SIZE-1:0]     mem_read_data_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] MaxBase = ADDRESS_WIDTH'(MEMORY_SIZE - 3);
  localparam logic [ADDRESS_WIDTH-1:0] MidBase = ADDRESS_WIDTH'(MEMORY_SIZE - 2);

  state_e                   state_q;
  logic                     write_q;
  logic                     byte_q;
  logic [1:0]               lane_q;
  logic [7:0]               wbyte_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_SIZE-1:0]     wdata_q;
  logic [DATA_SIZE-1:0]     rdata_q;
  logic                     error_q;

  logic                     acceptError;
  logic [ADDRESS_WIDTH-1:0] acceptBase;
  logic [1:0]               acceptLane;
  logic [7:0]               laneByte;
  logic [DATA_SIZE-1:0]     mergedWord;

  // Byte ops near the top slide the word window down so base+2 stays in memory.
  always_comb begin
    acceptError = 1'b0;
    acceptBase  = req_addr_i;
    acceptLane  = 2'd0;
    if (req_addr_i > MaxBase) begin
      if (req_byte_i) begin
        acceptBase = MaxBase;
        acceptLane = (req_addr_i == MidBase) ? 2'd1 : 2'd2;
      end else begin
        acceptError = 1'b1;
      end
    end
  end

  always_comb begin
    laneByte   = mem_read_data_i[23:16];
    mergedWord = mem_read_data_i;
    case (lane_q)
      2'd0: begin
        laneByte          = mem_read_data_i[23:16];
        mergedWord[23:16] = wbyte_q;
      end
      2'd1: begin
        laneByte         = mem_read_data_i[15:8];
        mergedWord[15:8] = wbyte_q;
      end
      default: begin
        laneByte        = mem_read_data_i[7:0];
        mergedWord[7:0] = wbyte_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 2'd0;
      wbyte_q <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            byte_q  <= req_byte_i;
            lane_q  <= acceptLane;
            wbyte_q <= req_wdata_i[7:0];
            if (acceptError) begin
              error_q <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end else begin
              error_q <= 1'b0;
              addr_q  <= acceptBase;
              if (req_write_i && !req_byte_i) begin
                wdata_q <= req_wdata_i;
                state_q <= WRITE;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        // Only byte stores reach READ with a write pending.
        READ: begin
          if (write_q) begin
            wdata_q <= mergedWord;
            state_q <= WRITE;
          end else begin
            rdata_q <= byte_q ? {{(DATA_SIZE-8){1'b0}}, laneByte} : mem_read_data_i;
            state_q <= RESP;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o        = (state_q == IDLE);
  assign rsp_valid_o        = (state_q == RESP);
  assign rsp_rdata_o        = rdata_q;
  assign rsp_error_o        = error_q;
  assign mem_write_enable_o = (state_q == WRITE);
  assign mem_address_o      = addr_q;
  assign mem_write_data_o   = wdata_q;

endmodule

// File: tb/tb_sic_mem_access_unit.sv
// Randomised bench for sic_mem_access_unit: a transaction-level model with a byte-array memory image
// predicts every cycle's outputs; directed scenarios pin the model with hand-computed values.
module tb_sic_mem_access_unit;

  localparam int MemSize = 32768;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic        reqByte = 1'b0;
  logic [14:0] reqAddr = '0;
  logic [23:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [23:0] rspRdata;
  logic        rspError;
  logic        memWe;
  logic [14:0] memAddr;
  logic [23:0] memWdata;
  logic [23:0] memRdata;

  int nVectors = 0;
  int nMiscompares = 0;
  bit checkEn = 1'b0;

  logic [7:0] memArr [0:MemSize-1];
  logic [7:0] refMem [0:MemSize-1];
  bit         initMem = 1'b0;
  bit         preloadEn = 1'b0;
  int         preloadAddr = 0;
  logic [23:0] preloadWord = '0;

  bit          mBusy = 1'b0;
  int          mAge = 0;
  int          mLat = 0;
  int          mWeAge = 0;
  bit          mErr = 1'b0;
  int          mBase = 0;
  logic [23:0] mRdata = '0;
  logic [23:0] mWdata = '0;

  logic [23:0] lastRdata;
  logic        lastErr;
  logic [14:0] lastAddr;
  int          lastLat;
  int          lastWe;

  sic_mem_access_unit dut (
    .clk               (clk),
    .rst_n             (rstN),
    .req_valid_i       (reqValid),
    .req_ready_o       (reqReady),
    .req_write_i       (reqWrite),
    .req_byte_i        (reqByte),
    .req_addr_i        (reqAddr),
    .req_wdata_i       (reqWdata),
    .rsp_valid_o       (rspValid),
    .rsp_ready_i       (rspReady),
    .rsp_rdata_o       (rspRdata),
    .rsp_error_o       (rspError),
    .mem_write_enable_o(memWe),
    .mem_address_o     (memAddr),
    .mem_write_data_o  (memWdata),
    .mem_read_data_i   (memRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 29 + 7) ^ (i >> 7));
  endfunction

  // Physical memory: combinational big-endian read, whole-word write on the clock edge.
  always_comb begin
    memRdata[23:16] = memArr[memAddr];
    memRdata[15:8]  = (memAddr == 15'h7FFF) ? 8'h00 : memArr[memAddr + 15'd1];
    memRdata[7:0]   = (memAddr >= 15'h7FFE) ? 8'h00 : memArr[memAddr + 15'd2];
  end

  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < MemSize; i++) memArr[i] <= pattern(i);
    end else if (preloadEn) begin
      memArr[preloadAddr]     <= preloadWord[23:16];
      memArr[preloadAddr + 1] <= preloadWord[15:8];
      memArr[preloadAddr + 2] <= preloadWord[7:0];
    end else if (memWe) begin
      memArr[int'(memAddr)]     <= memWdata[23:16];
      memArr[int'(memAddr) + 1] <= memWdata[15:8];
      memArr[int'(memAddr) + 2] <= memWdata[7:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by its age in edges since accept.
  initial begin : model
    int a;
    int lane;
    logic [7:0] wb [3];
    forever begin
      @(posedge clk or negedge rstN);
      if (initMem) begin
        for (int i = 0; i < MemSize; i++) refMem[i] = pattern(i);
      end else if (preloadEn) begin
        refMem[preloadAddr]     = preloadWord[23:16];
        refMem[preloadAddr + 1] = preloadWord[15:8];
        refMem[preloadAddr + 2] = preloadWord[7:0];
      end
      if (!rstN) begin
        mBusy = 1'b0;
      end else if (mBusy) begin
        if (mWeAge != 0 && mAge == mWeAge) begin
          refMem[mBase]     = mWdata[23:16];
          refMem[mBase + 1] = mWdata[15:8];
          refMem[mBase + 2] = mWdata[7:0];
        end
        if (mAge >= mLat && rspReady) mBusy = 1'b0;
        else mAge++;
      end else if (reqValid) begin
        a = int'(reqAddr);
        mBusy = 1'b1; mAge = 1; mWeAge = 0; mErr = 1'b0; mRdata = '0; mWdata = '0;
        if (reqByte) begin
          mBase = (a > MemSize - 3) ? MemSize - 3 : a;
          lane  = a - mBase;
        end else begin
          mBase = a;
          lane  = 0;
          mErr  = (a > MemSize - 3);
        end
        if (mErr) begin
          mLat = 1;
        end else if (!reqWrite) begin
          mLat = 2;
          if (reqByte) mRdata = {16'h0000, refMem[mBase + lane]};
          else mRdata = {refMem[mBase], refMem[mBase + 1], refMem[mBase + 2]};
        end else if (!reqByte) begin
          mLat = 2; mWeAge = 1; mWdata = reqWdata;
        end else begin
          mLat = 3; mWeAge = 2;
          wb[0] = refMem[mBase]; wb[1] = refMem[mBase + 1]; wb[2] = refMem[mBase + 2];
          wb[lane] = reqWdata[7:0];
          mWdata = {wb[0], wb[1], wb[2]};
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("req_ready", 32'(reqReady), 32'(!mBusy));
      checkOutput("rsp_valid", 32'(rspValid), 32'(mBusy && mAge >= mLat));
      checkOutput("mem_we", 32'(memWe), 32'(mBusy && mWeAge != 0 && mAge == mWeAge));
      if (mBusy && mAge >= mLat) begin
        checkOutput("rsp_rdata", 32'(rspRdata), 32'(mRdata));
        checkOutput("rsp_error", 32'(rspError), 32'(mErr));
      end
      if (mBusy && !mErr && mAge < mLat) checkOutput("mem_address", 32'(memAddr), 32'(mBase));
      if (mBusy && mWeAge != 0 && mAge == mWeAge) checkOutput("mem_wdata", 32'(memWdata), 32'(mWdata));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(reqReady), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, 32'(rspRdata), 32'd0);
    checkOutput({tag, "_rsp_error"}, 32'(rspError), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(memWdata), 32'd0);
  endtask

  task automatic preload(input int addr, input logic [23:0] word);
    @(negedge clk);
    preloadEn = 1'b1; preloadAddr = addr; preloadWord = word;
    @(posedge clk); #1;
    preloadEn = 1'b0;
  endtask

  // One request from an idle unit with rsp_ready held high; latency counts edges from accept to rsp_valid.
  task automatic applyStimulus(input logic w, input logic b, input logic [14:0] a, input logic [23:0] wd);
    int lat;
    int weCnt;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqByte = b; reqAddr = a; reqWdata = wd; rspReady = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 1; weCnt = 0; lastAddr = memAddr;
    while (!rspValid && lat < 8) begin
      if (memWe) weCnt++;
      @(posedge clk); #1;
      lat++;
    end
    lastLat = lat; lastWe = weCnt; lastRdata = rspRdata; lastErr = rspError;
    @(posedge clk); #1;
  endtask

  function automatic logic [14:0] pickAddr();
    int r;
    r = $urandom_range(0, 7);
    if (r < 5) return 15'h0400 + 15'($urandom_range(0, 31));
    else if (r < 7) return 15'h7FF8 + 15'($urandom_range(0, 7));
    else return 15'($urandom);
  endfunction

  initial begin : stimulus
    int waitCnt;
    int diffs;
    initMem = 1'b1;
    @(posedge clk); #1;
    initMem = 1'b0;
    @(posedge clk); #1;
    checkResetValues("reset");
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    checkResetValues("post_reset");
    checkEn = 1'b1;

    applyStimulus(1'b1, 1'b0, 15'h0100, 24'hABCDEF);
    checkOutput("wst_latency", 32'(lastLat), 32'd2);
    checkOutput("wst_we_pulses", 32'(lastWe), 32'd1);
    checkOutput("wst_error", 32'(lastErr), 32'd0);
    checkOutput("wst_rdata", 32'(lastRdata), 32'd0);
    checkOutput("wst_mem", 32'({memArr[32'h100], memArr[32'h101], memArr[32'h102]}), 32'hABCDEF);
    applyStimulus(1'b0, 1'b0, 15'h0100, 24'h0);
    checkOutput("wld_rdata", 32'(lastRdata), 32'hABCDEF);
    checkOutput("wld_latency", 32'(lastLat), 32'd2);
    checkOutput("wld_error", 32'(lastErr), 32'd0);

    preload(32'h200, 24'h112233);
    applyStimulus(1'b1, 1'b1, 15'h0201, 24'hFFFF5A);
    checkOutput("bst_latency", 32'(lastLat), 32'd3);
    checkOutput("bst_we_pulses", 32'(lastWe), 32'd1);
    checkOutput("bst_mem", 32'({memArr[32'h200], memArr[32'h201], memArr[32'h202]}), 32'h115A33);
    applyStimulus(1'b0, 1'b1, 15'h0201, 24'h0);
    checkOutput("bld_rdata", 32'(lastRdata), 32'h00005A);
    checkOutput("bld_latency", 32'(lastLat), 32'd2);

    preload(32'h7FFD, 24'hAABBCC);
    applyStimulus(1'b0, 1'b1, 15'h7FFF, 24'h0);
    checkOutput("top_bld2_rdata", 32'(lastRdata), 32'h0000CC);
    checkOutput("top_bld2_addr", 32'(lastAddr), 32'h7FFD);
    applyStimulus(1'b0, 1'b1, 15'h7FFE, 24'h0);
    checkOutput("top_bld1_rdata", 32'(lastRdata), 32'h0000BB);
    checkOutput("top_bld1_addr", 32'(lastAddr), 32'h7FFD);
    applyStimulus(1'b1, 1'b1, 15'h7FFF, 24'h000077);
    checkOutput("top_bst_mem", 32'({memArr[32'h7FFD], memArr[32'h7FFE], memArr[32'h7FFF]}), 32'hAABB77);

    applyStimulus(1'b0, 1'b0, 15'h7FFE, 24'h0);
    checkOutput("err_ld_error", 32'(lastErr), 32'd1);
    checkOutput("err_ld_rdata", 32'(lastRdata), 32'd0);
    checkOutput("err_ld_latency", 32'(lastLat), 32'd1);
    applyStimulus(1'b1, 1'b0, 15'h7FFF, 24'h123456);
    checkOutput("err_st_error", 32'(lastErr), 32'd1);
    checkOutput("err_st_latency", 32'(lastLat), 32'd1);
    checkOutput("err_st_we_pulses", 32'(lastWe), 32'd0);
    checkOutput("err_st_mem", 32'({memArr[32'h7FFD], memArr[32'h7FFE], memArr[32'h7FFF]}), 32'hAABB77);

    // Back-pressure: response must hold while rsp_ready is low and req_valid stays asserted.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqByte = 1'b0; reqAddr = 15'h0100; rspReady = 1'b0;
    waitCnt = 0;
    while (!rspValid && waitCnt < 8) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("hold_valid_seen", 32'(rspValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rspValid), 32'd1);
      checkOutput("hold_rdata", 32'(rspRdata), 32'hABCDEF);
      checkOutput("hold_error", 32'(rspError), 32'd0);
      checkOutput("hold_req_ready", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_req_ready", 32'(reqReady), 32'd1);
    checkOutput("hs_rsp_valid", 32'(rspValid), 32'd0);
    @(posedge clk); #1;
    checkOutput("next_accepted", 32'(reqReady), 32'd0);
    reqValid = 1'b0;
    waitCnt = 0;
    while (mBusy && waitCnt < 10) begin
      @(posedge clk); #1;
      waitCnt++;
    end

    // Reset in the read phase of a byte store must leave memory untouched.
    preload(32'h300, 24'h445566);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b1; reqAddr = 15'h0301; reqWdata = 24'h000099;
    @(posedge clk); #2;
    reqValid = 1'b0;
    rstN = 1'b0;
    #1;
    checkResetValues("midop_reset");
    @(posedge clk); #2;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("midop_mem", 32'({memArr[32'h300], memArr[32'h301], memArr[32'h302]}), 32'h445566);
    applyStimulus(1'b0, 1'b0, 15'h0300, 24'h0);
    checkOutput("after_reset_load", 32'(lastRdata), 32'h445566);
    checkOutput("after_reset_latency", 32'(lastLat), 32'd2);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reqValid = ($urandom_range(0, 2) != 0);
      reqWrite = 1'($urandom_range(0, 1));
      reqByte  = 1'($urandom_range(0, 1));
      reqAddr  = pickAddr();
      reqWdata = 24'($urandom);
      rspReady = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    reqValid = 1'b0; rspReady = 1'b1;
    waitCnt = 0;
    while (mBusy && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("drain_idle", 32'(mBusy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    diffs = 0;
    for (int i = 0; i < MemSize; i++) if (memArr[i] !== refMem[i]) diffs++;
    checkOutput("memory_image_diffs", 32'(diffs), 32'd0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
